// File: rtl/sm_pkg.sv
// Shared types and default timing for the stepper-motor move controller.
// Contents: FSM state enum, 50 MHz default timing constants, and the width
// helper for the saturating period adder.
package sm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StDone
    } sm_state_e;

    // Defaults for a 50 MHz system clock.
    localparam int unsigned DefWidthWork = 16;
    localparam int unsigned DefWidthPer  = 16;
    localparam int unsigned DefWidthPos  = 24;
    localparam int unsigned DefPulseHi   = 50;     // 1 us
    localparam int unsigned DefDirSetup  = 25;
    localparam int unsigned DefPStart    = 50000;  // 1 kHz
    localparam int unsigned DefPMin      = 5000;   // 10 kHz
    localparam int unsigned DefPDec      = 100;

    // One guard bit above the period width so period + P_DEC cannot wrap
    // before the saturation compare.
    localparam int unsigned PerGuardBits = 1;

    function automatic int unsigned per_sum_width(int unsigned width_per);
        return width_per + PerGuardBits;
    endfunction

endpackage

// File: rtl/sm_move_ctrl_if.sv
// Move-command bus for sm_move_ctrl.
// Signals: cmd_valid/cmd_ready handshake, cmd_steps (unsigned step count),
// cmd_dir (1 = positive), abort (level-sensitive early stop).
// Modports: master = command source, slave = move controller.
interface sm_move_ctrl_if #(
    parameter int unsigned WIDTH_WORK = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [WIDTH_WORK-1:0] cmd_steps;
    logic                  cmd_dir;
    logic                  abort;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_dir,
        output abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_dir,
        input  abort,
        output cmd_ready
    );
endinterface

// File: rtl/sm_ramp.sv
// Step-period ramp generator.
// Holds the current step period and the acceleration step count. On load
// the ramp restarts at P_START; on each step strobe it either decelerates
// (when the remaining steps no longer cover the acceleration already done),
// accelerates toward P_MIN, or cruises.
// Ports: clk, rst (async, active-high), load (restart ramp), step (one step
// issued, rem sampled before its decrement), rem (remaining steps),
// period (current step period in clk cycles).
module sm_ramp
    import sm_pkg::*;
#(
    parameter int unsigned WIDTH_WORK = DefWidthWork,
    parameter int unsigned WIDTH_PER  = DefWidthPer,
    parameter int unsigned P_START    = DefPStart,
    parameter int unsigned P_MIN      = DefPMin,
    parameter int unsigned P_DEC      = DefPDec
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [WIDTH_WORK-1:0] rem,
    output logic [WIDTH_PER-1:0]  period
);

    localparam int unsigned SumW = per_sum_width(WIDTH_PER);

    logic [WIDTH_WORK-1:0] acc_q, acc_d;
    logic [WIDTH_PER-1:0]  period_d;
    logic [SumW-1:0]       period_ext;
    logic [SumW-1:0]       period_inc;
    logic [WIDTH_WORK-1:0] rem_m1;
    logic                  decel;

    always_comb begin
        period_ext = SumW'(period);
        period_inc = period_ext + SumW'(P_DEC);
        rem_m1     = rem - WIDTH_WORK'(1);
        // rem is never zero on a step; the guard only keeps rem_m1 meaningful.
        decel      = (acc_q != '0) && (rem != '0) && (rem_m1 <= acc_q);

        period_d = period;
        acc_d    = acc_q;
        if (load) begin
            period_d = WIDTH_PER'(P_START);
            acc_d    = '0;
        end else if (step) begin
            if (decel) begin
                period_d = (period_inc > SumW'(P_START)) ? WIDTH_PER'(P_START)
                                                         : WIDTH_PER'(period_inc);
                acc_d    = acc_q - WIDTH_WORK'(1);
            end else if (period > WIDTH_PER'(P_MIN)) begin
                // Compare before subtracting so the result never underflows.
                period_d = (period_ext >= SumW'(P_MIN) + SumW'(P_DEC))
                         ? WIDTH_PER'(period_ext - SumW'(P_DEC))
                         : WIDTH_PER'(P_MIN);
                acc_d    = acc_q + WIDTH_WORK'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= WIDTH_PER'(P_START);
            acc_q  <= '0;
        end else begin
            period <= period_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/sm_move_ctrl.sv
// Stepper-motor move sequencer.
// Accepts a move command over the cmd bus, enables the driver for the move,
// emits exactly cmd_steps ramped step pulses and tracks a signed position.
// Ports: clk, rst (async, active-high), cmd (command bus, slave side),
// drv_step/drv_dir/drv_SM (driver pins), busy (not idle), done (one-cycle
// completion/abort pulse), pos (signed position, wraps).
module sm_move_ctrl
    import sm_pkg::*;
#(
    parameter int unsigned WIDTH_WORK = DefWidthWork,
    parameter int unsigned WIDTH_PER  = DefWidthPer,
    parameter int unsigned WIDTH_POS  = DefWidthPos,
    parameter int unsigned PULSE_HI   = DefPulseHi,
    parameter int unsigned DIR_SETUP  = DefDirSetup,
    parameter int unsigned P_START    = DefPStart,
    parameter int unsigned P_MIN      = DefPMin,
    parameter int unsigned P_DEC      = DefPDec
) (
    input  logic                 clk,
    input  logic                 rst,
    sm_move_ctrl_if.slave        cmd,
    output logic                 drv_step,
    output logic                 drv_dir,
    output logic                 drv_SM,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH_POS-1:0] pos
);

    if (!((P_MIN > PULSE_HI) && ((P_START >> WIDTH_PER) == 0) &&
          (PULSE_HI > 0) && (DIR_SETUP > 0))) begin : g_param_check
        $error("sm_move_ctrl: illegal timing parameters");
    end

    sm_state_e             state_q, state_d;
    logic [WIDTH_PER-1:0]  cnt_q, cnt_d;
    logic [WIDTH_WORK-1:0] rem_q, rem_d;
    logic                  abort_q, abort_d;
    logic                  dir_d;
    logic [WIDTH_POS-1:0]  pos_d;
    logic                  accept;
    logic                  go_high;
    logic                  ramp_load;
    logic [WIDTH_PER-1:0]  period;

    assign cmd.cmd_ready = (state_q == StIdle) && !cmd.abort;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        abort_d   = abort_q;
        dir_d     = drv_dir;
        pos_d     = pos;
        go_high   = 1'b0;
        ramp_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cmd.cmd_steps == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StSetup;
                        rem_d     = cmd.cmd_steps;
                        dir_d     = cmd.cmd_dir;
                        cnt_d     = WIDTH_PER'(DIR_SETUP - 1);
                        ramp_load = 1'b1;
                    end
                end
            end
            StSetup: begin
                if (cmd.abort) begin
                    state_d = StDone;
                end else if (cnt_q == '0) begin
                    go_high = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH_PER'(1);
                end
            end
            StHigh: begin
                // Abort is remembered so a short abort during the pulse still
                // ends the move once the pulse has finished.
                if (cmd.abort) begin
                    abort_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    if ((rem_q == '0) || abort_q || cmd.abort) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLow;
                        cnt_d   = period - WIDTH_PER'(PULSE_HI + 1);
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH_PER'(1);
                end
            end
            StLow: begin
                if (cmd.abort) begin
                    state_d = StDone;
                end else if (cnt_q == '0) begin
                    go_high = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH_PER'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                abort_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (go_high) begin
            state_d = StHigh;
            cnt_d   = WIDTH_PER'(PULSE_HI - 1);
            rem_d   = rem_q - WIDTH_WORK'(1);
            pos_d   = drv_dir ? pos + WIDTH_POS'(1) : pos - WIDTH_POS'(1);
        end
    end

    sm_ramp #(
        .WIDTH_WORK (WIDTH_WORK),
        .WIDTH_PER  (WIDTH_PER),
        .P_START    (P_START),
        .P_MIN      (P_MIN),
        .P_DEC      (P_DEC)
    ) u_ramp (
        .clk    (clk),
        .rst    (rst),
        .load   (ramp_load),
        .step   (go_high),
        .rem    (rem_q),
        .period (period)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            abort_q  <= 1'b0;
            drv_step <= 1'b0;
            drv_dir  <= 1'b0;
            drv_SM   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pos      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            abort_q  <= abort_d;
            // Outputs are registered decodes of the next state.
            drv_step <= (state_d == StHigh);
            drv_dir  <= dir_d;
            drv_SM   <= (state_d == StSetup) || (state_d == StHigh) || (state_d == StLow);
            busy     <= (state_d != StIdle);
            done     <= (state_d == StDone);
            pos      <= pos_d;
        end
    end

endmodule

// File: tb/tb_sm_move_ctrl.sv
// Self-checking bench for sm_move_ctrl with shortened timing
// (PULSE_HI=4, DIR_SETUP=3, P_START=20, P_MIN=10, P_DEC=5).
// Cycle T=0 is the cycle whose closing edge performs the handshake.
module tb_sm_move_ctrl;

    logic        clk;
    logic        rst;
    logic        drv_step;
    logic        drv_dir;
    logic        drv_SM;
    logic        busy;
    logic        done;
    logic [23:0] pos;

    int errors;
    int checks;

    sm_move_ctrl_if #(.WIDTH_WORK(16)) bus ();

    sm_move_ctrl #(
        .PULSE_HI  (4),
        .DIR_SETUP (3),
        .P_START   (20),
        .P_MIN     (10),
        .P_DEC     (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (bus),
        .drv_step (drv_step),
        .drv_dir  (drv_dir),
        .drv_SM   (drv_SM),
        .busy     (busy),
        .done     (done),
        .pos      (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int steps;
        bit dir;
        int abort_pulse;  // abort on 2nd HIGH cycle of this pulse, 0 = never
        bit do_reset;
        int exp_n;
        int exp_done;
        int exp_pos;
        int exp_r[5];     // first rise times, -1 = none expected
        int exp_iv[2];    // last two rise-to-rise intervals, 0 = skip
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, done_t, hi, bad_w, last_r, iv_last, iv_prev, extra;
        int r[5];
        logic prev, sm1, sm_any;

        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_steps = '0;
        bus.cmd_dir   = 1'b0;
        bus.abort     = 1'b0;

        vecs[0] = '{5,   1'b1, 0, 1'b1, 5,   68,   5,   '{4, 19, 29, 44, 64}, '{15, 20}};
        vecs[1] = '{0,   1'b1, 0, 1'b0, 0,   1,    5,   '{-1, -1, -1, -1, -1}, '{0, 0}};
        vecs[2] = '{1,   1'b0, 0, 1'b0, 1,   8,    4,   '{4, -1, -1, -1, -1}, '{0, 0}};
        vecs[3] = '{100, 1'b1, 0, 1'b0, 100, 1018, 104, '{4, 19, 29, 39, 49}, '{15, 20}};
        vecs[4] = '{10,  1'b1, 3, 1'b1, 3,   33,   3,   '{4, 19, 29, -1, -1}, '{15, 10}};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_drv_step", {31'b0, drv_step}, 0);
        check("rst_drv_dir",  {31'b0, drv_dir}, 0);
        check("rst_drv_SM",   {31'b0, drv_SM}, 0);
        check("rst_busy",     {31'b0, busy}, 0);
        check("rst_done",     {31'b0, done}, 0);
        check("rst_pos",      {8'b0, pos}, 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_reset) do_reset();
            @(negedge clk);
            bus.cmd_steps = 16'(vecs[v].steps);
            bus.cmd_dir   = vecs[v].dir;
            bus.cmd_valid = 1'b1;
            check($sformatf("v%0d_ready", v), {31'b0, bus.cmd_ready}, 1);
            @(posedge clk);
            #1 bus.cmd_valid = 1'b0;

            n = 0; done_t = -1; hi = 0; bad_w = 0; last_r = 0;
            iv_last = 0; iv_prev = 0; prev = 1'b0; sm1 = 1'b0; sm_any = 1'b0;
            for (int k = 0; k < 5; k++) r[k] = -1;

            for (int t = 1; t <= 2000 && done_t < 0; t++) begin
                @(negedge clk);
                if (t == 1) sm1 = drv_SM;
                if (drv_SM) sm_any = 1'b1;
                if (drv_step && !prev) begin
                    if (n < 5) r[n] = t;
                    iv_prev = iv_last;
                    iv_last = t - last_r;
                    last_r  = t;
                    n++;
                    hi = 0;
                end
                if (drv_step) hi++;
                if (!drv_step && prev && hi != 4) bad_w++;
                prev = drv_step;
                if (vecs[v].abort_pulse != 0 && n == vecs[v].abort_pulse && drv_step && hi == 2)
                    bus.abort = 1'b1;
                if (done) done_t = t;
            end
            bus.abort = 1'b0;

            check($sformatf("v%0d_done_time", v), done_t, vecs[v].exp_done);
            check($sformatf("v%0d_pulses", v), n, vecs[v].exp_n);
            check($sformatf("v%0d_pos", v), {8'b0, pos}, vecs[v].exp_pos);
            check($sformatf("v%0d_width_errs", v), bad_w, 0);
            check($sformatf("v%0d_sm_t1", v), {31'b0, sm1}, {31'b0, vecs[v].steps != 0});
            check($sformatf("v%0d_sm_seen", v), {31'b0, sm_any}, {31'b0, vecs[v].steps != 0});
            check($sformatf("v%0d_sm_at_done", v), {31'b0, drv_SM}, 0);
            for (int k = 0; k < 5; k++)
                if (vecs[v].exp_r[k] >= 0)
                    check($sformatf("v%0d_rise%0d", v, k), r[k], vecs[v].exp_r[k]);
            if (vecs[v].exp_iv[0] != 0)
                check($sformatf("v%0d_iv_prev", v), iv_prev, vecs[v].exp_iv[0]);
            if (vecs[v].exp_iv[1] != 0)
                check($sformatf("v%0d_iv_last", v), iv_last, vecs[v].exp_iv[1]);

            extra = 0;
            prev = drv_step;
            repeat (20) begin
                @(negedge clk);
                if (drv_step && !prev) extra++;
                prev = drv_step;
            end
            check($sformatf("v%0d_no_extra_pulse", v), extra, 0);
            check($sformatf("v%0d_idle_busy", v), {31'b0, busy}, 0);
        end

        // abort held in IDLE blocks the handshake
        do_reset();
        @(negedge clk);
        bus.abort     = 1'b1;
        bus.cmd_steps = 16'd2;
        bus.cmd_dir   = 1'b1;
        bus.cmd_valid = 1'b1;
        #1 check("abort_blocks_ready", {31'b0, bus.cmd_ready}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_no_accept%0d", k), {31'b0, busy}, 0);
        end
        bus.abort = 1'b0;
        #1 check("ready_after_abort_release", {31'b0, bus.cmd_ready}, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("accepted_busy", {31'b0, busy}, 1);
        check("accepted_sm", {31'b0, drv_SM}, 1);

        // async reset in the middle of LOW (first rise at t=4, LOW from t=8)
        repeat (9) @(negedge clk);
        check("midlow_pos", {8'b0, pos}, 1);
        check("midlow_step", {31'b0, drv_step}, 0);
        check("midlow_sm", {31'b0, drv_SM}, 1);
        rst = 1'b1;
        #1;
        check("arst_drv_SM", {31'b0, drv_SM}, 0);
        check("arst_busy",   {31'b0, busy}, 0);
        check("arst_pos",    {8'b0, pos}, 0);
        check("arst_drv_dir", {31'b0, drv_dir}, 0);
        check("arst_drv_step", {31'b0, drv_step}, 0);
        check("arst_done",   {31'b0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_move_ctrl.md
Name: sm_move_ctrl

Overview:
Move sequencer for the stepper-motor (SM) driver. It accepts a move command (step count and direction) over a valid/ready handshake and asserts drv_SM for the duration of the move. It emits exactly that many drv_step pulses using a linear acceleration/deceleration period ramp, and keeps a signed absolute position count. It sits between the ADC-derived move computation and the SM driver pins, replacing free-running pulse generation with a bounded, ramped sequence.

Parameters:
WIDTH_WORK, 16, width of cmd_steps and the internal remaining/accel counters
WIDTH_PER, 16, width of the step-period counter in clk cycles
WIDTH_POS, 24, width of the signed position counter
PULSE_HI, 50, drv_step high time in clk cycles (1 us at 50 MHz)
DIR_SETUP, 25, cycles from the drv_dir update to the first drv_step rise
P_START, 50000, initial and maximum step period in cycles (1 kHz)
P_MIN, 5000, minimum step period in cycles (10 kHz)
P_DEC, 100, period change per step while ramping

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  move command valid
cmd_ready  out  1  controller can accept a command
cmd_steps  in  WIDTH_WORK  number of steps to emit (unsigned)
cmd_dir  in  1  direction: 1 = positive, 0 = negative
abort  in  1  stop the move early, level-sensitive
drv_step  out  1  step pulse to the SM driver
drv_dir  out  1  direction to the SM driver
drv_SM  out  1  SM driver enable, high while moving
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a command completes or is aborted
pos  out  WIDTH_POS  signed absolute step position

Behaviour:
- Reset (asynchronous): state IDLE; drv_step=0, drv_dir=0, drv_SM=0, busy=0, done=0, pos=0; period=P_START; internal counters 0.
- cmd_ready = (state==IDLE) && !abort. Handshake occurs on cycle T when cmd_valid && cmd_ready.
- States: IDLE, SETUP, HIGH, LOW, DONE. All outputs are registered.
- IDLE, handshake with cmd_steps==0: go to DONE. drv_SM stays 0, no pulse, pos unchanged.
- IDLE, handshake with cmd_steps>0: latch rem=cmd_steps; drv_dir=cmd_dir; period=P_START; acc=0; go to SETUP. drv_SM=1 from T+1.
- SETUP lasts DIR_SETUP cycles. First drv_step high at cycle T+1+DIR_SETUP.
- HIGH: drv_step=1 for PULSE_HI cycles.
- On entering HIGH:
  - pos += 1 if drv_dir else -1, wrapping modulo 2^WIDTH_POS.
  - Ramp update, using rem before decrement:
    - if acc>0 and rem-1 <= acc: period=min(period+P_DEC, P_START), acc-=1;
    - else if period>P_MIN: period=max(period-P_DEC, P_MIN), acc+=1;
    - else period unchanged.
  - Then rem-=1.
- End of HIGH: if rem==0, go to DONE; else go to LOW.
- LOW lasts (period - PULSE_HI) cycles, then HIGH. Rise-to-rise spacing equals the updated period.
- DONE: one cycle; done=1, drv_SM=0, drv_step=0; then IDLE.
- Arithmetic: the period computation is at least WIDTH_PER+1 bits wide, so saturation never wraps.
- Legality: P_MIN > PULSE_HI and P_START <= 2^WIDTH_PER-1 are checked by a static assertion.
- Abort:
  - In SETUP: go to DONE next cycle, no pulse emitted.
  - In HIGH: the pulse always completes its full PULSE_HI, then DONE.
  - In LOW: go to DONE next cycle.
  - In IDLE: ignored, except that it blocks cmd_ready.
  - abort and cmd_valid together in IDLE: the command is not accepted.
- cmd_valid while busy: ignored. The command is held by the source until the handshake.
- rst mid-move: all outputs return to reset values immediately, including pos.

Decomposition:
- Package sm_pkg holds:
  - state enum (IDLE, SETUP, HIGH, LOW, DONE);
  - default timing constants for 50 MHz;
  - a localparam helper for the period adder width.
- One sub-module, sm_ramp: a registered period/acc update taking rem, acc, period and a step-enable strobe, and producing the next period and acc. The FSM, timing counter and position counter stay in the top.

Test Plan:
(Bench parameters: PULSE_HI=4, DIR_SETUP=3, P_START=20, P_MIN=10, P_DEC=5.)
- Reset while idle, then cmd_steps=5, dir=1 accepted at T=0 -> drv_SM=1 from T=1. drv_step rises at T=4, 19, 29, 44, 64 (intervals 15, 10, 15, 20). Each pulse is 4 cycles high. done=1 at T=68; pos=5; drv_SM=0 at T=68.
- cmd_steps=0 -> done pulses at T+1. No drv_step, drv_SM stays 0, pos unchanged.
- cmd_steps=1, dir=0 from pos=5 -> single pulse at T=4. done at T=8; pos=4.
- cmd_steps=100 -> period saturates at 10 (cruise). Deceleration starts when rem-1 <= acc. Final intervals are 15 then 20; exactly 100 pulses.
- Abort asserted on the 2nd cycle of the 3rd pulse's HIGH -> the pulse completes its 4 cycles, done follows. pos=3; no further pulses.
- cmd_valid held with abort=1 in IDLE -> cmd_ready=0, no acceptance. abort released -> accepted the next cycle. rst asserted mid-LOW -> all outputs 0 asynchronously.
